mac_column_engine: RTL and testbench
====================================

Name: mac_column_engine

Overview:
- Datapath responder to the matrix-vector calculation controller: it executes one column per ALU_en window.
- Per column it performs N_MUL multiply-accumulates of coefficient ROM words against the loaded X vector.
- It writes the column result to result RAM, returns a one-cycle column-complete strobe (web), and pulses ALU_done after the last column.
- It sits between the X input shift buffer, the coefficient ROM, the result RAM and the controller FSM.

Parameters:
- DATA_W, 8, X element width.
- COEF_W, 8, coefficient width.
- N_MUL, 8, MACs per column.
- N_COL, 4, columns per matrix.
- ACC_W, 19, accumulator and result width. Holds N_MUL*(2^8-1)^2 = 520200 without overflow.
- CA_W, 5, coefficient ROM address width (log2(N_MUL*N_COL)).
- RA_W, 2, result RAM address width (log2(N_COL)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ALU_en  in  1  column-compute enable from controller, held high for the whole ALU state.
- x_data  in  N_MUL*DATA_W  loaded X vector; element k = bits [k*DATA_W +: DATA_W]; stable while ALU_en=1.
- coef_addr  out  CA_W  coefficient ROM read address, registered.
- coef_data  in  COEF_W  ROM read data, valid 1 cycle after coef_addr.
- ram_addr  out  RA_W  result RAM write address (= current column).
- ram_data  out  ACC_W  result RAM write data.
- web  out  1  active-high write strobe, 1 cycle per column; controller uses it as column-done.
- ALU_done  out  1  1-cycle pulse after final column written.

Behaviour:
Reset (rst=0, async): all outputs 0; state IDLE; col=0; k=0; acc=0.

States:
- IDLE. On ALU_en=1: go to MAC; k=0; acc=0; coef_addr=col*N_MUL.
- MAC (N_MUL+1 cycles, k=0..N_MUL):
  - For k<N_MUL: coef_addr = col*N_MUL+k.
  - For k>=1: acc += coef_data * x_data[k-1]. The ROM's 1-cycle latency is absorbed by this offset.
  - After the k=N_MUL cycle: go to WRITE.
- WRITE (1 cycle): web=1, ram_addr=col, ram_data=acc (registered outputs). Go to DRAIN.
- DRAIN:
  - Wait for ALU_en=0, which the controller provides through its next_col state.
  - On ALU_en=0: col increments and go to IDLE.
  - If the old col==N_COL-1: ALU_done=1 for that one cycle and col wraps to 0.

Timing and arithmetic:
- Latency: web is high in the cycle following the (N_MUL+2)th rising edge after the edge that first samples ALU_en=1 (10 edges for defaults).
- Arithmetic is unsigned by default. Product width DATA_W+COEF_W, zero-extended to ACC_W. No saturation is needed at the default sizes.
- web and ALU_done are never high in the same cycle.

Boundary conditions:
- ALU_en falls during MAC: abort. acc is cleared, col is unchanged, no web is issued, go to IDLE. The column restarts from k=0 on the next ALU_en.
- ALU_en falls in the same cycle as WRITE: the write still completes and DRAIN exits on the next cycle.
- ALU_en stays high in DRAIN: hold indefinitely, with no second web.
- Reset mid-column: immediate return to the reset state. No partial write is issued and col=0.
- ram_addr and ram_data hold their last written values between writes. coef_addr holds its last value outside MAC.

Optional Feature:
- Macro: SIGNED_MAC_EN.
- Defined:
  - x_data elements and coef_data are two's complement.
  - Products are sign-extended to ACC_W before accumulation.
  - ram_data is a signed result.
  - ACC_W must then cover N_MUL*2^(DATA_W+COEF_W-2) magnitude; 19 is sufficient for the defaults.
- Undefined: all operands unsigned with zero-extension, as above.

Test Plan:
1. Reset then single column: x=1..8, ROM words 0-7 all 1, pulse ALU_en from IDLE. Required: coef_addr steps 0..7, web high exactly 1 cycle at edge 10, ram_addr=0, ram_data=36.
2. Full matrix: ROM word i = i+1, x all 2; run 4 ALU_en windows separated by 1 low cycle. Required: ram_data = 72, 200, 328, 456 at addresses 0-3; ALU_done single pulse after the 4th DRAIN exit; col back to 0.
3. Overflow bound: all x=255, all coef=255. Required: each column result 520200, no wrap.
4. Abort: drop ALU_en at MAC k=4, re-raise 2 cycles later. Required: no web during the aborted window; the next write is for column 0 with the full correct sum.
5. Async reset asserted during MAC of column 2. Required: all outputs 0 immediately; after release a new run starts at column 0 and coef_addr 0.
6. With SIGNED_MAC_EN: x all -1 (0xFF), coef all 2. Required: ram_data = -16 (0x7FFF0 in 19 bits). Without the macro the same stimulus gives 4080.

Source files
------------

// File: rtl/mac_column_engine.sv
// Column MAC engine: one N_MUL-term dot product of coefficient ROM words against x_data per ALU_en window.
// Optional macro SIGNED_MAC_EN selects two's-complement operands; the default build is unsigned.
module mac_column_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int N_MUL  = 8,
    parameter int N_COL  = 4,
    parameter int ACC_W  = 19,
    parameter int CA_W   = 5,
    parameter int RA_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ALU_en,
    input  logic [N_MUL*DATA_W-1:0]   x_data,
    output logic [CA_W-1:0]           coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic [RA_W-1:0]           ram_addr,
    output logic [ACC_W-1:0]          ram_data,
    output logic                      web,
    output logic                      ALU_done
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int KW     = $clog2(N_MUL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DRAIN
    } state_t;

    state_t             state_q;
    logic [KW-1:0]      k_q;
    logic [RA_W-1:0]    col_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CA_W-1:0]    coefAddr_q;
    logic [CA_W-1:0]    colBase;
    logic [RA_W-1:0]    ramAddr_q;
    logic [ACC_W-1:0]   ramData_q;
    logic               web_q;
    logic               done_q;
    logic [DATA_W-1:0]  xSel;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   prodExt;

    // ROM data lags its address by one cycle, so step k pairs with x element k-1.
    always_comb begin
        xSel = '0;
        for (int i = 0; i < N_MUL; i++) begin
            if (k_q == KW'(i + 1)) begin
                xSel = x_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SIGNED_MAC_EN
    assign prod    = PROD_W'($signed(xSel)) * PROD_W'($signed(coef_data));
    assign prodExt = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`else
    assign prod    = PROD_W'(xSel) * PROD_W'(coef_data);
    assign prodExt = {{(ACC_W-PROD_W){1'b0}}, prod};
`endif

    assign acc_d   = acc_q + prodExt;
    assign colBase = CA_W'(col_q) * CA_W'(N_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            coefAddr_q <= '0;
            ramAddr_q  <= '0;
            ramData_q  <= '0;
            web_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            web_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ALU_en) begin
                        state_q    <= S_MAC;
                        k_q        <= '0;
                        acc_q      <= '0;
                        coefAddr_q <= colBase;
                    end
                end
                S_MAC: begin
                    if (!ALU_en) begin
                        // Abort: the column restarts from scratch on the next window.
                        state_q <= S_IDLE;
                        k_q     <= '0;
                        acc_q   <= '0;
                    end else begin
                        if (k_q != '0) begin
                            acc_q <= acc_d;
                        end
                        if (k_q == KW'(N_MUL)) begin
                            state_q <= S_WRITE;
                            k_q     <= '0;
                        end else begin
                            k_q <= k_q + 1'b1;
                            if (k_q < KW'(N_MUL - 1)) begin
                                coefAddr_q <= colBase + CA_W'(k_q) + CA_W'(1);
                            end
                        end
                    end
                end
                S_WRITE: begin
                    web_q     <= 1'b1;
                    ramAddr_q <= col_q;
                    ramData_q <= acc_q;
                    state_q   <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!ALU_en) begin
                        state_q <= S_IDLE;
                        if (col_q == RA_W'(N_COL - 1)) begin
                            col_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign coef_addr = coefAddr_q;
    assign ram_addr  = ramAddr_q;
    assign ram_data  = ramData_q;
    assign web       = web_q;
    assign ALU_done  = done_q;

endmodule

// File: tb/tb_mac_column_engine.sv
// Self-checking bench for mac_column_engine: edge-count reference model, directed scenarios and random windows.
// Honours SIGNED_MAC_EN the same way as the design.
module tb_mac_column_engine;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int N_MUL  = 8;
    localparam int N_COL  = 4;
    localparam int ACC_W  = 19;
    localparam int CA_W   = 5;
    localparam int RA_W   = 2;

    logic                    clk;
    logic                    rst;
    logic                    ALU_en;
    logic [N_MUL*DATA_W-1:0] x_data;
    logic [CA_W-1:0]         coef_addr;
    logic [COEF_W-1:0]       coef_data;
    logic [RA_W-1:0]         ram_addr;
    logic [ACC_W-1:0]        ram_data;
    logic                    web;
    logic                    ALU_done;

    logic [COEF_W-1:0] rom [N_MUL*N_COL];

    int checks  = 0;
    int passes  = 0;
    int doneCnt = 0;
    bit compareOn = 1'b0;

    logic [RA_W-1:0]  wAddrQ [$];
    logic [ACC_W-1:0] wDataQ [$];

    typedef enum {M_IDLE, M_BUSY, M_DRAIN} mstate_t;
    mstate_t           mState = M_IDLE;
    int                n      = 0;
    int                mCol   = 0;
    logic [CA_W-1:0]   eCoef  = '0;
    logic [RA_W-1:0]   eRa    = '0;
    logic [ACC_W-1:0]  eRd    = '0;
    logic              eWeb   = 1'b0;
    logic              eDone  = 1'b0;

    mac_column_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .N_MUL(N_MUL), .N_COL(N_COL),
        .ACC_W(ACC_W), .CA_W(CA_W), .RA_W(RA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ALU_en   (ALU_en),
        .x_data   (x_data),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .web      (web),
        .ALU_done (ALU_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) coef_data <= rom[coef_addr];

    // Dot product of one column, done with plain integer arithmetic.
    function automatic logic [ACC_W-1:0] colSum(input int c);
        longint s;
        longint a;
        longint b;
        logic [DATA_W-1:0] xe;
        s = 0;
        for (int k = 0; k < N_MUL; k++) begin
            xe = x_data[k*DATA_W +: DATA_W];
            a  = longint'(xe);
            b  = longint'(rom[c*N_MUL + k]);
`ifdef SIGNED_MAC_EN
            if (xe[DATA_W-1]) a = a - (longint'(1) << DATA_W);
            if (rom[c*N_MUL + k][COEF_W-1]) b = b - (longint'(1) << COEF_W);
`endif
            s = s + a * b;
        end
        return s[ACC_W-1:0];
    endfunction

    // Reference model: n counts edges since the edge that first saw ALU_en high.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mState = M_IDLE;
            n      = 0;
            mCol   = 0;
            eCoef  = '0;
            eRa    = '0;
            eRd    = '0;
            eWeb   = 1'b0;
            eDone  = 1'b0;
        end else begin
            eWeb  = 1'b0;
            eDone = 1'b0;
            case (mState)
                M_IDLE: begin
                    if (ALU_en) begin
                        mState = M_BUSY;
                        n      = 0;
                        eCoef  = CA_W'(mCol * N_MUL);
                    end
                end
                M_BUSY: begin
                    n = n + 1;
                    if (n <= N_MUL + 1 && !ALU_en) begin
                        mState = M_IDLE;
                    end else begin
                        if (n < N_MUL) eCoef = CA_W'(mCol * N_MUL + n);
                        if (n == N_MUL + 2) begin
                            eWeb   = 1'b1;
                            eRa    = RA_W'(mCol);
                            eRd    = colSum(mCol);
                            mState = M_DRAIN;
                        end
                    end
                end
                default: begin
                    if (!ALU_en) begin
                        if (mCol == N_COL - 1) begin
                            mCol  = 0;
                            eDone = 1'b1;
                        end else begin
                            mCol = mCol + 1;
                        end
                        mState = M_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("coef_addr", 32'(coef_addr), 32'(eCoef));
            checkOutput("ram_addr", 32'(ram_addr), 32'(eRa));
            checkOutput("ram_data", 32'(ram_data), 32'(eRd));
            checkOutput("web", 32'(web), 32'(eWeb));
            checkOutput("ALU_done", 32'(ALU_done), 32'(eDone));
            checkOutput("web_and_done", 32'(web & ALU_done), 32'd0);
            if (web === 1'b1) begin
                wAddrQ.push_back(ram_addr);
                wDataQ.push_back(ram_data);
            end
            if (ALU_done === 1'b1) doneCnt++;
        end
    end

    task automatic assertReset(input string tag);
        #2;
        rst    = 1'b0;
        ALU_en = 1'b0;
        #1;
        checkOutput({tag, "_coef_addr"}, 32'(coef_addr), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_ram_data"}, 32'(ram_data), 32'd0);
        checkOutput({tag, "_web"}, 32'(web), 32'd0);
        checkOutput({tag, "_done"}, 32'(ALU_done), 32'd0);
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        assertReset(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge: one full window, then a single low cycle.
    task automatic runWindow();
        bit ok;
        ok     = 1'b0;
        ALU_en = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (web === 1'b1) ok = 1'b1;
        end
        checkOutput("window_web_seen", 32'(ok), 32'd1);
        ALU_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int hold, input int lowExtra);
        ALU_en = 1'b1;
        repeat (hold) @(negedge clk);
        ALU_en = 1'b0;
        @(negedge clk);
        x_data = {$urandom, $urandom};
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = COEF_W'($urandom);
        repeat (lowExtra) @(negedge clk);
    endtask

    initial begin
        int doneBefore;
        int t2Exp [4];
        int wBefore;
        logic [31:0] t6Exp;
        t2Exp  = '{72, 200, 328, 456};
        rst    = 1'b0;
        ALU_en = 1'b0;
        x_data = '0;
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        compareOn = 1'b1;

        $display("[TB] test 1: single column");
        for (int i = 0; i < N_MUL; i++) rom[i] = COEF_W'(1);
        for (int k = 0; k < N_MUL; k++) x_data[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        checkOutput("model_t1", 32'(colSum(0)), 32'd36);
        wAddrQ.delete(); wDataQ.delete();
        @(negedge clk);
        runWindow();
        checkOutput("t1_writes", 32'(wDataQ.size()), 32'd1);
        if (wDataQ.size() > 0) begin
            checkOutput("t1_addr", 32'(wAddrQ[0]), 32'd0);
            checkOutput("t1_data", 32'(wDataQ[0]), 32'd36);
        end

        $display("[TB] test 2: full matrix");
        resetDut("t2_rst");
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = COEF_W'(i + 1);
        for (int k = 0; k < N_MUL; k++) x_data[k*DATA_W +: DATA_W] = DATA_W'(2);
        checkOutput("model_t2", 32'(colSum(3)), 32'd456);
        wAddrQ.delete(); wDataQ.delete();
        doneBefore = doneCnt;
        for (int c = 0; c < N_COL; c++) runWindow();
        @(negedge clk);
        checkOutput("t2_writes", 32'(wDataQ.size()), 32'd4);
        for (int c = 0; c < N_COL && c < wDataQ.size(); c++) begin
            checkOutput("t2_addr", 32'(wAddrQ[c]), 32'(c));
            checkOutput("t2_data", 32'(wDataQ[c]), 32'(t2Exp[c]));
        end
        checkOutput("t2_done_pulses", 32'(doneCnt - doneBefore), 32'd1);

        $display("[TB] test 3: overflow bound");
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = 8'hFF;
        x_data = '1;
        wAddrQ.delete(); wDataQ.delete();
        for (int c = 0; c < N_COL; c++) runWindow();
        checkOutput("t3_writes", 32'(wDataQ.size()), 32'd4);
        if (wDataQ.size() > 0) checkOutput("t3_first_addr", 32'(wAddrQ[0]), 32'd0);
`ifndef SIGNED_MAC_EN
        for (int c = 0; c < wDataQ.size(); c++) checkOutput("t3_data", 32'(wDataQ[c]), 32'd520200);
`endif

        $display("[TB] test 4: abort mid-column");
        resetDut("t4_rst");
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = COEF_W'(i + 1);
        for (int k = 0; k < N_MUL; k++) x_data[k*DATA_W +: DATA_W] = DATA_W'(2);
        wAddrQ.delete(); wDataQ.delete();
        ALU_en = 1'b1;
        repeat (5) @(negedge clk);
        ALU_en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t4_no_web_abort", 32'(wDataQ.size()), 32'd0);
        runWindow();
        checkOutput("t4_writes", 32'(wDataQ.size()), 32'd1);
        if (wDataQ.size() > 0) begin
            checkOutput("t4_addr", 32'(wAddrQ[0]), 32'd0);
            checkOutput("t4_data", 32'(wDataQ[0]), 32'd72);
        end

        $display("[TB] test 5: reset mid-column");
        resetDut("t5_rst0");
        runWindow();
        runWindow();
        wBefore = wDataQ.size();
        ALU_en = 1'b1;
        repeat (4) @(negedge clk);
        assertReset("t5_rst");
        @(negedge clk);
        rst = 1'b1;
        checkOutput("t5_no_partial", 32'(wDataQ.size()), 32'(wBefore));
        runWindow();
        if (wDataQ.size() > wBefore) begin
            checkOutput("t5_addr", 32'(wAddrQ[wBefore]), 32'd0);
            checkOutput("t5_data", 32'(wDataQ[wBefore]), 32'd72);
        end

        $display("[TB] test 6: signedness");
        for (int i = 0; i < N_MUL*N_COL; i++) rom[i] = COEF_W'(2);
        x_data = '1;
`ifdef SIGNED_MAC_EN
        t6Exp = 32'h7FFF0;
`else
        t6Exp = 32'd4080;
`endif
        checkOutput("model_t6", 32'(colSum(0)), t6Exp);
        wBefore = wDataQ.size();
        runWindow();
        if (wDataQ.size() > wBefore) checkOutput("t6_data", 32'(wDataQ[wBefore]), t6Exp);

        $display("[TB] random windows");
        for (int it = 0; it < 60; it++) begin
            applyStimulus($urandom_range(1, 14), $urandom_range(0, 2));
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
